// File: rtl/operand_stack.sv
// Data stack feeding the ALU: top/next live in registers, deeper entries spill to a circular buffer.
// Define OPERAND_STACK_GUARD_EN to suppress overflowing/underflowing ops and raise a sticky err.
module operand_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               op,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         top,
    output logic [WIDTH-1:0]         next,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     empty,
    output logic                     full,
    output logic                     err
);

    localparam int PW = $clog2(DEPTH);
    localparam int DW = PW + 1;
    localparam logic [DW-1:0] D_FULL = DW'(DEPTH);
    localparam logic [DW-1:0] D_ZERO = '0;
    localparam logic [DW-1:0] D_ONE  = DW'(1);
    localparam logic [DW-1:0] D_TWO  = DW'(2);

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_REPL = 3'd3,
        OP_BIN  = 3'd4,
        OP_DUP  = 3'd5
    } op_t;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    sp;
    logic [PW-1:0]    sp_n;
    logic [WIDTH-1:0] top_n;
    logic [WIDTH-1:0] next_n;
    logic [WIDTH-1:0] spill_top;
    logic [DW-1:0]    depth_n;
    logic             mem_we;
    logic             fault;
    logic             is_empty;
    logic             has_two;
    logic             has_spill;
    logic             at_full;

    assign is_empty  = (depth == D_ZERO);
    assign has_two   = (depth >= D_TWO);
    assign has_spill = (depth > D_TWO);
    assign at_full   = (depth == D_FULL);
    assign spill_top = mem[sp - PW'(1)];

`ifdef OPERAND_STACK_GUARD_EN
    logic underflow;
    logic overflow;

    always_comb begin
        underflow = 1'b0;
        overflow  = 1'b0;
        case (op)
            OP_PUSH: overflow = at_full;
            OP_POP, OP_REPL: underflow = is_empty;
            OP_BIN:  underflow = !has_two;
            OP_DUP: begin
                underflow = is_empty;
                overflow  = at_full;
            end
            default: ;
        endcase
    end

    assign fault = underflow | overflow;

    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (fault)
            err <= 1'b1;
    end
`else
    assign fault = 1'b0;
    assign err   = 1'b0;
`endif

    // Registers beyond the current depth are kept at zero, so missing operands read as 0 for free.
    always_comb begin
        top_n   = top;
        next_n  = next;
        sp_n    = sp;
        depth_n = depth;
        mem_we  = 1'b0;
        case (op)
            OP_PUSH, OP_DUP: begin
                if (op == OP_PUSH)
                    top_n = wdata;
                next_n = top;
                if (has_two) begin
                    mem_we = 1'b1;
                    sp_n   = sp + PW'(1);
                end
                if (!at_full)
                    depth_n = depth + D_ONE;
            end
            OP_POP: begin
                top_n  = next;
                next_n = has_spill ? spill_top : '0;
                if (has_spill)
                    sp_n = sp - PW'(1);
                if (!is_empty)
                    depth_n = depth - D_ONE;
            end
            OP_REPL: begin
                if (!is_empty)
                    top_n = wdata;
            end
            OP_BIN: begin
                if (!is_empty)
                    top_n = wdata;
                next_n = has_spill ? spill_top : '0;
                if (has_spill)
                    sp_n = sp - PW'(1);
                if (has_two)
                    depth_n = depth - D_ONE;
            end
            default: ;
        endcase
        if (fault) begin
            top_n   = top;
            next_n  = next;
            sp_n    = sp;
            depth_n = depth;
            mem_we  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top   <= '0;
            next  <= '0;
            sp    <= '0;
            depth <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            top   <= top_n;
            next  <= next_n;
            sp    <= sp_n;
            depth <= depth_n;
            empty <= (depth_n == D_ZERO);
            full  <= (depth_n == D_FULL);
        end
    end

    // On overflow the pointer keeps advancing; the oldest slot simply falls out of reach.
    always_ff @(posedge clk) begin
        if (mem_we && !rst)
            mem[sp] <= next;
    end

endmodule

// File: doc/operand_stack.md
# operand_stack

- Hardware data stack for the 16-bit stack CPU; sits directly upstream of the ALU.
- Drives the ALU's `a` input from the current top-of-stack and `b` from the next entry, both straight from registers.
- Takes the ALU result back through `wdata` and applies the push/pop/replace the decoder requests.
- One operation completes per cycle, so a binary ALU instruction (pop two, push result) retires in a single clock.

## Interface
Parameters:
- `WIDTH`, 16, data word width.
- `DEPTH`, 16, maximum logical entries; power of two, ≥ 4.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `op`  in  3  stack operation sampled each rising edge: 000 NOP, 001 PUSH, 010 POP, 011 REPL, 100 BIN, 101 DUP; 110/111 behave as NOP.
- `wdata`  in  WIDTH  value written by PUSH, REPL and BIN (the ALU `out`).
- `top`  out  WIDTH  entry 0 (top of stack); feeds ALU `a`.
- `next`  out  WIDTH  entry 1; feeds ALU `b`.
- `depth`  out  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- `empty`  out  1  depth == 0.
- `full`  out  1  depth == DEPTH.
- `err`  out  1  sticky overflow/underflow flag; see Configuration.

## Operation
- Logical model: entries e[0]=top .. e[depth-1]=bottom. Positions ≥ depth read as 0 on `top`/`next`.
- Operations:
  - PUSH: e[0]←wdata, others shift down, depth+1.
  - POP: shift up, depth−1.
  - REPL: e[0]←wdata, depth unchanged. Used for unary ALU ops (INC, NOT, SIGN…).
  - BIN: e[0]←wdata, e[1..] ← old e[2..], depth−1. Used for binary ALU ops (ADD, SUB, LT…).
  - DUP: push old e[0], depth+1.
- Implementation choice is free: `top`/`next` registers plus a circular spill buffer is expected. Externally visible state must match the logical model exactly.
- Underflow conditions:
  - POP, REPL or DUP with depth 0.
  - BIN with depth < 2.
- Overflow condition: PUSH or DUP with depth == DEPTH.
- Reset: depth=0, `top`=`next`=0, `empty`=1, `full`=0, `err`=0, all buffer contents treated as invalid. Reset overrides any `op` in the same cycle, including mid-sequence.

## Timing
- `op`/`wdata` are sampled at edge N. New `top`, `next`, `depth`, `empty`, `full` and `err` are visible after edge N, i.e. latency 1.
- `top`, `next`, `depth`, `empty`, `full` and `err` are pure register outputs with no combinational path from `op`/`wdata`. The ALU loop `top`→ALU→`wdata` therefore closes in one cycle.
- Back-to-back operations every cycle are supported with no bubbles or stalls.
- Wrap-around of the internal buffer pointer is invisible. After more than DEPTH alternating push/pop ops the values are still correct.

## Configuration
- `OPERAND_STACK_GUARD_EN` defined:
  - An overflowing or underflowing op is suppressed entirely: no state change.
  - `err` is set to 1 after that edge and held until `rst`.
- Macro undefined:
  - `err` is tied to 0.
  - Overflow executes anyway, the bottom entry is discarded and depth stays DEPTH.
  - Underflow executes with missing operands reading as 0. Depth saturates at 0, and BIN at depth 1 leaves depth 1 with e[0]=wdata.

## Test plan
- Reset, then PUSH 0xDEAD, PUSH 0xBEEF → `top`=0xBEEF, `next`=0xDEAD, `depth`=2, `empty`=0.
- From depth 2 with `top`=0x2101, `next`=0x70FF, BIN with `wdata`=0x9200 → `top`=0x9200, `next`=0, `depth`=1, all one cycle after sampling.
- REPL 0xDEAE on depth 1, then DUP, then POP → `top` reads 0xDEAE after each op, `depth` goes 1→2→1.
- Fill with PUSH 1..DEPTH → `full`=1, `top`=DEPTH.
  - Guard build: PUSH 0x55 leaves `top`=DEPTH, `depth`=DEPTH, `err`=1.
  - Non-guard build: `top`=0x55, `depth`=DEPTH, and after DEPTH−1 POPs the bottom reads 2.
- From empty, POP:
  - Guard build: `depth`=0, `err`=1 and stays 1 through later legal ops until `rst`.
  - Non-guard build: `depth`=0, `top`=0, `err`=0.
- Assert `rst` in the same cycle as PUSH 0x1234 at depth 3 → next cycle `depth`=0, `top`=0, `err`=0. Then 40 alternating PUSH i / POP ops return correct values across pointer wrap.
